// File: rtl/pipe_ctrl.sv
// Pipeline controller for the 5-stage core. It merges stage stall requests, sequences exception
// flushes through a short recovery window, and tracks stall time for a watchdog and a perf counter.
module pipe_ctrl #(
    parameter int RECOVER_CYCLES = 2,
    parameter int WDOG_LIMIT     = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_if,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        stallreq_mem,
    input  logic        excp_valid,
    input  logic [31:0] excp_handler,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic        in_recover,
    output logic        stall_timeout,
    output logic [31:0] stall_cycles
);

    typedef enum logic {
        RUN,
        RECOVER
    } state_t;

    localparam logic [3:0]  REC_LOAD = 4'(RECOVER_CYCLES - 1);
    localparam logic [15:0] WDOG_MAX = 16'(WDOG_LIMIT);

    state_t      state;
    state_t      state_next;
    logic [3:0]  rec_cnt;
    logic [3:0]  rec_cnt_next;
    logic [15:0] wdog_cnt;
    logic [15:0] wdog_next;
    logic [5:0]  stall_req;

    // A stalled stage also freezes every stage upstream of it, so the highest requester wins.
    always_comb begin
        stall_req = 6'b000000;
        if (stallreq_mem) begin
            stall_req = 6'b011111;
        end else if (stallreq_ex) begin
            stall_req = 6'b001111;
        end else if (stallreq_id) begin
            stall_req = 6'b000111;
        end else if (stallreq_if) begin
            stall_req = 6'b000011;
        end
    end

    always_comb begin
        stall        = 6'b000000;
        flush        = 1'b0;
        new_pc       = 32'h0000_0000;
        state_next   = state;
        rec_cnt_next = rec_cnt;
        if (!rst) begin
            case (state)
                RUN: begin
                    if (excp_valid) begin
                        flush        = 1'b1;
                        new_pc       = excp_handler;
                        state_next   = RECOVER;
                        rec_cnt_next = REC_LOAD;
                    end else begin
                        stall = stall_req;
                    end
                end
                RECOVER: begin
                    stall = stall_req;
                    if (rec_cnt == 4'd0) begin
                        state_next = RUN;
                    end else begin
                        rec_cnt_next = rec_cnt - 4'd1;
                    end
                end
                default: begin
                    state_next = RUN;
                end
            endcase
        end
    end

    // Watchdog counts consecutive frozen-PC cycles and holds at the limit while the stall persists.
    always_comb begin
        wdog_next = 16'd0;
        if (stall[0] && !flush) begin
            wdog_next = (wdog_cnt == WDOG_MAX) ? wdog_cnt : wdog_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= RUN;
            rec_cnt       <= 4'd0;
            wdog_cnt      <= 16'd0;
            stall_timeout <= 1'b0;
            stall_cycles  <= 32'd0;
        end else begin
            state         <= state_next;
            rec_cnt       <= rec_cnt_next;
            wdog_cnt      <= wdog_next;
            stall_timeout <= (wdog_next == WDOG_MAX);
            stall_cycles  <= stall_cycles + 32'(stall[0]);
        end
    end

    assign in_recover = (state == RECOVER);

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed vector table, a watchdog sequence and a random phase,
// all compared against a cycle-level behavioural model of the controller.
module tb_pipe_ctrl;

    localparam int RECOVER_CYCLES = 2;
    localparam int WDOG_LIMIT     = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
    logic        excp_valid;
    logic [31:0] excp_handler;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        in_recover;
    logic        stall_timeout;
    logic [31:0] stall_cycles;

    pipe_ctrl #(
        .RECOVER_CYCLES(RECOVER_CYCLES),
        .WDOG_LIMIT(WDOG_LIMIT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .stallreq_if(stallreq_if),
        .stallreq_id(stallreq_id),
        .stallreq_ex(stallreq_ex),
        .stallreq_mem(stallreq_mem),
        .excp_valid(excp_valid),
        .excp_handler(excp_handler),
        .stall(stall),
        .flush(flush),
        .new_pc(new_pc),
        .in_recover(in_recover),
        .stall_timeout(stall_timeout),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state: whether a recovery window is open and how many of its cycles remain.
    bit          m_recovering = 0;
    int          m_rec_left   = 0;
    int          m_wdog       = 0;
    bit          m_timeout    = 0;
    logic [31:0] m_cycles     = 0;

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic        excp;
        logic [31:0] handler;
        logic [5:0]  e_stall;
        logic        e_flush;
        logic [31:0] e_pc;
        logic        e_rec;
        logic [31:0] e_cycles;
    } vec_t;

    vec_t vecs[20];

    function automatic vec_t mk(logic r, logic [3:0] q, logic x, logic [31:0] h, logic [5:0] s,
                                logic f, logic [31:0] p, logic rc, logic [31:0] c);
        vec_t v;
        v.rst = r; v.req = q; v.excp = x; v.handler = h; v.e_stall = s;
        v.e_flush = f; v.e_pc = p; v.e_rec = rc; v.e_cycles = c;
        return v;
    endfunction

    // Freeze depth from the deepest requesting stage: mem freezes 5 bits, ex 4, id 3, if 2.
    function automatic logic [5:0] model_stall(logic [3:0] q);
        int depth;
        depth = q[3] ? 5 : q[2] ? 4 : q[1] ? 3 : q[0] ? 2 : 0;
        return 6'((1 << depth) - 1);
    endfunction

    task automatic cmp(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    task automatic applyStimulus(logic r, logic [3:0] q, logic x, logic [31:0] h);
        @(negedge clk);
        rst          = r;
        stallreq_mem = q[3];
        stallreq_ex  = q[2];
        stallreq_id  = q[1];
        stallreq_if  = q[0];
        excp_valid   = x;
        excp_handler = h;
        #1;
    endtask

    task automatic checkOutput();
        logic        f_e;
        logic [5:0]  s_e;
        logic [31:0] p_e;
        f_e = !rst && !m_recovering && excp_valid;
        s_e = (rst || f_e) ? 6'd0 : model_stall({stallreq_mem, stallreq_ex, stallreq_id, stallreq_if});
        p_e = f_e ? excp_handler : 32'd0;
        cmp("model_stall", 32'(stall), 32'(s_e));
        cmp("model_flush", 32'(flush), 32'(f_e));
        cmp("model_new_pc", new_pc, p_e);
        cmp("model_in_recover", 32'(in_recover), 32'(m_recovering));
        cmp("model_timeout", 32'(stall_timeout), 32'(m_timeout));
        cmp("model_stall_cycles", stall_cycles, m_cycles);
    endtask

    task automatic stepModel();
        bit f_e;
        bit s0;
        @(posedge clk);
        if (rst) begin
            m_recovering = 0; m_rec_left = 0; m_wdog = 0; m_timeout = 0; m_cycles = 0;
        end else begin
            f_e = !m_recovering && excp_valid;
            s0  = !f_e && (stallreq_mem || stallreq_ex || stallreq_id || stallreq_if);
            if (f_e) begin
                m_recovering = 1;
                m_rec_left   = RECOVER_CYCLES;
            end else if (m_recovering) begin
                m_rec_left--;
                if (m_rec_left == 0) m_recovering = 0;
            end
            m_wdog    = s0 ? ((m_wdog + 1 > WDOG_LIMIT) ? WDOG_LIMIT : m_wdog + 1) : 0;
            m_timeout = s0 && (m_wdog == WDOG_LIMIT);
            if (s0) m_cycles = m_cycles + 32'd1;
        end
    endtask

    initial begin
        int burst;
        logic [3:0] q;
        // Request bits are {mem, ex, id, if}.
        vecs[0]  = mk(1, 4'b0100, 0, 32'h0,        6'b000000, 0, 32'h0,        0, 0);
        vecs[1]  = mk(0, 4'b0100, 0, 32'h0,        6'b001111, 0, 32'h0,        0, 0);
        vecs[2]  = mk(0, 4'b0100, 0, 32'h0,        6'b001111, 0, 32'h0,        0, 1);
        vecs[3]  = mk(0, 4'b0100, 0, 32'h0,        6'b001111, 0, 32'h0,        0, 2);
        vecs[4]  = mk(0, 4'b0000, 0, 32'h0,        6'b000000, 0, 32'h0,        0, 3);
        vecs[5]  = mk(0, 4'b1011, 0, 32'h0,        6'b011111, 0, 32'h0,        0, 3);
        vecs[6]  = mk(0, 4'b0011, 0, 32'h0,        6'b000111, 0, 32'h0,        0, 4);
        vecs[7]  = mk(0, 4'b0000, 0, 32'h0,        6'b000000, 0, 32'h0,        0, 5);
        vecs[8]  = mk(0, 4'b0100, 1, 32'hBFC00380, 6'b000000, 1, 32'hBFC00380, 0, 5);
        vecs[9]  = mk(0, 4'b0000, 1, 32'h80000180, 6'b000000, 0, 32'h0,        1, 5);
        vecs[10] = mk(0, 4'b0000, 0, 32'h0,        6'b000000, 0, 32'h0,        1, 5);
        vecs[11] = mk(0, 4'b0000, 0, 32'h0,        6'b000000, 0, 32'h0,        0, 5);
        vecs[12] = mk(0, 4'b0000, 1, 32'h80000180, 6'b000000, 1, 32'h80000180, 0, 5);
        vecs[13] = mk(0, 4'b0100, 0, 32'h0,        6'b001111, 0, 32'h0,        1, 5);
        vecs[14] = mk(0, 4'b1000, 0, 32'h0,        6'b011111, 0, 32'h0,        1, 6);
        vecs[15] = mk(0, 4'b1000, 0, 32'h0,        6'b011111, 0, 32'h0,        0, 7);
        vecs[16] = mk(0, 4'b1000, 1, 32'h00000100, 6'b000000, 1, 32'h00000100, 0, 8);
        vecs[17] = mk(1, 4'b1000, 0, 32'h0,        6'b000000, 0, 32'h0,        1, 8);
        vecs[18] = mk(0, 4'b1000, 0, 32'h0,        6'b011111, 0, 32'h0,        0, 0);
        vecs[19] = mk(0, 4'b0000, 0, 32'h0,        6'b000000, 0, 32'h0,        0, 1);

        applyStimulus(1, 4'b0000, 0, 32'h0);
        stepModel();
        applyStimulus(1, 4'b0000, 0, 32'h0);
        stepModel();

        for (int i = 0; i < 20; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].req, vecs[i].excp, vecs[i].handler);
            checkOutput();
            cmp($sformatf("vec%0d_stall", i), 32'(stall), 32'(vecs[i].e_stall));
            cmp($sformatf("vec%0d_flush", i), 32'(flush), 32'(vecs[i].e_flush));
            cmp($sformatf("vec%0d_new_pc", i), new_pc, vecs[i].e_pc);
            cmp($sformatf("vec%0d_in_recover", i), 32'(in_recover), 32'(vecs[i].e_rec));
            cmp($sformatf("vec%0d_stall_cycles", i), stall_cycles, vecs[i].e_cycles);
            cmp($sformatf("vec%0d_timeout", i), 32'(stall_timeout), 32'd0);
            stepModel();
        end

        // Watchdog: six held mem stalls, then release; timeout is visible after the fourth stalled edge.
        for (int k = 1; k <= 8; k++) begin
            applyStimulus(0, (k <= 6) ? 4'b1000 : 4'b0000, 0, 32'h0);
            checkOutput();
            cmp($sformatf("wdog_timeout_c%0d", k), 32'(stall_timeout),
                ((k >= 5) && (k <= 7)) ? 32'd1 : 32'd0);
            stepModel();
        end

        burst = 0;
        for (int n = 0; n < 400; n++) begin
            if (burst == 0 && $urandom_range(0, 15) == 0) burst = $urandom_range(3, 9);
            q = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
            if (burst > 0) begin
                q[3] = 1'b1;
                burst--;
            end
            applyStimulus($urandom_range(0, 99) == 0, q, $urandom_range(0, 11) == 0, $urandom);
            checkOutput();
            stepModel();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central pipeline controller for the 5-stage core. It merges per-stage stall requests into the stall vector that freezes the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It sequences exception flushes, with a redirect PC and a recovery window. It also tracks stall duration for a watchdog and a free-running stall-cycle performance counter.

Parameters:
RECOVER_CYCLES, 2, cycles spent in RECOVER after a flush; legal range 1..15.
WDOG_LIMIT, 1024, consecutive stalled cycles that raise stall_timeout; legal range 1..65535.

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  synchronous reset, active-high
stallreq_if  in  1  fetch stage requests stall
stallreq_id  in  1  decode stage requests stall
stallreq_ex  in  1  execute stage requests stall (multi-cycle mul/div)
stallreq_mem  in  1  memory stage requests stall
excp_valid  in  1  committed exception/eret detected in MEM this cycle
excp_handler  in  32  redirect target for excp_valid
stall  out  6  freeze vector: bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 WB (reserved, always 0)
flush  out  1  clear all pipeline registers to NOP this cycle
new_pc  out  32  PC load value, valid when flush=1
in_recover  out  1  FSM is in RECOVER
stall_timeout  out  1  watchdog expired (sticky until stall released)
stall_cycles  out  32  total cycles with stall[0]=1

Behaviour:
- Interface: reset rst, synchronous, active-high; clock clk.
- Reset: state=RUN, recover counter=0, watchdog counter=0, stall_timeout=0, stall_cycles=0. While rst=1: stall=0, flush=0, new_pc=0 (gated combinationally).
- stall, flush and new_pc are combinational from the inputs and the current state, giving zero latency. All other outputs are registered.
- Stall priority applies when no flush occurs, highest first:
  - mem: 6'b011111
  - ex: 6'b001111
  - id: 6'b000111
  - if: 6'b000011
  - none: 6'b000000
  - Lower-priority requests are subsumed by higher ones.
- FSM RUN:
  - excp_valid=1 gives flush=1, new_pc=excp_handler and stall=0, overriding every stall request.
  - On that flush, the next state is RECOVER and the recover counter loads RECOVER_CYCLES-1.
  - With excp_valid=0, stall follows the priority table, flush=0 and new_pc=0.
- FSM RECOVER:
  - in_recover=1; excp_valid is ignored, because the flushed instruction cannot re-raise.
  - Stall requests are still honoured per the table.
  - When the counter is 0, the next state is RUN; otherwise the counter decrements each cycle, including stalled cycles.
  - RECOVER therefore lasts exactly RECOVER_CYCLES cycles.
- Watchdog:
  - The counter increments each cycle with stall[0]=1, saturating at WDOG_LIMIT.
  - The counter clears on any cycle with stall[0]=0 or flush=1.
  - stall_timeout is set the cycle after the counter reaches WDOG_LIMIT. It clears on the same edge the counter clears.
- stall_cycles increments on each cycle with stall[0]=1 and wraps 0xFFFFFFFF -> 0.
- Simultaneous excp_valid and stall requests in RUN: the flush wins, and the cycle is not counted as stalled.
- rst asserted mid-RECOVER or mid-stall: the next cycle is RUN with all counters zero.

Test Plan:
- Reset, then stallreq_ex=1 for 3 cycles -> stall=6'b001111 on exactly those 3 cycles; stall_cycles=3 afterwards.
- stallreq_if=1, stallreq_id=1 and stallreq_mem=1 in the same cycle -> stall=6'b011111. Drop stallreq_mem -> stall=6'b000111 in the same cycle.
- In RUN, excp_valid=1 with excp_handler=0xBFC00380 and stallreq_ex=1 -> flush=1, new_pc=0xBFC00380, stall=0. in_recover=1 for exactly 2 cycles, then RUN.
- During RECOVER, excp_valid=1 with handler 0x80000180 -> flush=0, new_pc=0, state unaffected. After returning to RUN, a new excp_valid flushes normally.
- With WDOG_LIMIT=4, hold stallreq_mem=1 -> stall_timeout rises after the 4th stalled cycle and stays high. Release the stall -> stall_timeout=0 on the next cycle.
- Assert rst mid-RECOVER with a stall pending -> the next cycle has in_recover=0, stall_timeout=0 and stall_cycles=0, and stall follows the requests again once rst drops.
